// File: rtl/program_loader.sv
// program_loader: host-side master of the CPU program-download interface.
// Accepts a framed byte stream over a valid/ready handshake:
//   SYNC_BYTE, LEN_LO, LEN_HI, then 2*N data bytes (each instruction low byte first),
//   then one XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
// Each assembled 16-bit instruction is presented on program_in together with its
// word index on instruction_index; download_program holds the CPU in download mode
// from SYNC acceptance until the frame finishes or fails.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (default build: no checksum).
module program_loader #(
  parameter int         MAX_WORDS = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        download_program,
  output logic [31:0] instruction_index,
  output logic [15:0] program_in,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    CSUM,
    FINISH
  } state_t;

  // Length limit widened by one bit so the comparison never truncates.
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic        dl_q, dl_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] prog_q, prog_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] n_q, n_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [7:0]  low_q, low_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] len_w;
  logic [15:0] word_cnt_inc;

  assign accept       = byte_valid & byte_ready;
  assign len_w        = {byte_data, len_lo_q};
  assign word_cnt_inc = word_cnt_q + 16'd1;

  // State and datapath registers; reset clears everything including the outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dl_q       <= 1'b0;
      idx_q      <= '0;
      prog_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      len_lo_q   <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      low_q      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dl_q       <= dl_d;
      idx_q      <= idx_d;
      prog_q     <= prog_d;
      done_q     <= done_d;
      error_q    <= error_d;
      len_lo_q   <= len_lo_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      low_q      <= low_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Frame parser: next-state, handshake and output-update decisions.
  always_comb begin
    state_d    = state_q;
    dl_d       = dl_q;
    idx_d      = idx_q;
    prog_d     = prog_q;
    done_d     = 1'b0;
    error_d    = error_q;
    len_lo_d   = len_lo_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    low_d      = low_q;
    byte_ready = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          error_d = 1'b0;
          state_d = SYNC;
        end
      end

      SYNC: begin
        byte_ready = 1'b1;
        // Anything other than the marker is silently dropped.
        if (accept && (byte_data == SYNC_BYTE)) begin
          dl_d    = 1'b1;
          state_d = LEN_LO;
        end
      end

      LEN_LO: begin
        byte_ready = 1'b1;
        if (accept) begin
          len_lo_d = byte_data;
          state_d  = LEN_HI;
        end
      end

      LEN_HI: begin
        byte_ready = 1'b1;
        if (accept) begin
          n_d        = len_w;
          word_cnt_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
          if (len_w == 16'd0) begin
            // An empty program reports index 0 on completion.
            idx_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = FINISH;
`endif
          end else if ({1'b0, len_w} > MAX_LEN) begin
            error_d = 1'b1;
            dl_d    = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DATA_LO;
          end
        end
      end

      DATA_LO: begin
        byte_ready = 1'b1;
        if (accept) begin
          low_d   = byte_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ byte_data;
`endif
          state_d = DATA_HI;
        end
      end

      DATA_HI: begin
        byte_ready = 1'b1;
        if (accept) begin
          // Index and data move together so the cache never sees a mixed pair.
          prog_d     = {byte_data, low_q};
          idx_d      = word_cnt_q;
          word_cnt_d = word_cnt_inc;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_data;
`endif
          if (word_cnt_inc == n_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = FINISH;
`endif
          end else begin
            state_d = DATA_LO;
          end
        end
      end

      CSUM: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        byte_ready = 1'b1;
        if (accept) begin
          if (byte_data == csum_q) begin
            state_d = FINISH;
          end else begin
            // Words already written stay in the cache; the error flag tells the host.
            error_d = 1'b1;
            dl_d    = 1'b0;
            state_d = IDLE;
          end
        end
`else
        state_d = IDLE;
`endif
      end

      FINISH: begin
        dl_d    = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy              = (state_q != IDLE);
  assign download_program  = dl_q;
  assign instruction_index = {16'd0, idx_q};
  assign program_in        = prog_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Host-side master of the CPU program-download interface: drives `download_program`, `instruction_index` and `program_in`.
- Receives a framed byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Assembles little-endian 16-bit instructions and presents each one, with its word index, to the CPU's instruction cache.
- Holds the CPU in download mode for the whole frame and releases it when the frame completes.

Parameters:
- MAX_WORDS, 1024, largest accepted program length in 16-bit instructions; longer frames are rejected.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse; arms the loader to wait for a frame
- byte_valid  input  1  byte_data holds a valid byte this cycle
- byte_data  input  8  incoming stream byte
- byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid & byte_ready
- download_program  output  1  high while the CPU is held in download mode
- instruction_index  output  32  word index of program_in, zero-extended
- program_in  output  16  assembled instruction
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse on successful completion
- error  output  1  sticky failure flag; cleared by start or reset

Behaviour:
- Reset (reset_n=0 at a clock edge): state←IDLE; byte_ready, download_program, busy, done, error ←0; instruction_index←0; program_in←0.
  - Reset takes priority over everything, including mid-frame; download_program drops the cycle after reset is sampled.
- Frame format:
  - SYNC_BYTE, LEN_LO, LEN_HI. N = {LEN_HI,LEN_LO} is the number of instructions.
  - Then 2N data bytes, each instruction sent low byte first.
  - Then a checksum byte, only if the optional feature is enabled.
- States: IDLE, SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, FINISH.
- IDLE: byte_ready=0. On start: error←0, go to SYNC.
- SYNC: byte_ready=1.
  - An accepted byte ≠ SYNC_BYTE is discarded; stay in SYNC.
  - An accepted SYNC_BYTE → LEN_LO, and download_program←1 in the same edge.
- LEN_LO: the accepted byte is stored → LEN_HI.
- LEN_HI, on the accepted byte, form N:
  - N=0 → FINISH.
  - N>MAX_WORDS → error←1, download_program←0, → IDLE (no done pulse).
  - Otherwise word_cnt←0 → DATA_LO.
- DATA_LO: the accepted byte is held as the low byte → DATA_HI.
- DATA_HI, on the accepted byte:
  - program_in←{byte,low}; instruction_index←word_cnt; word_cnt←word_cnt+1.
  - Both outputs update on the same edge, so the pair is always consistent.
  - If word_cnt+1==N → CSUM if the feature is enabled, else FINISH; otherwise → DATA_LO.
- Output hold: program_in and instruction_index stay stable between updates. The cache may write every cycle while download_program=1; rewriting the same word is harmless.
- FINISH: lasts one cycle. download_program←0, done←1 for exactly one cycle, → IDLE. After completion, instruction_index holds N-1 (or 0 when N=0).
- Stalls: byte_valid=0 in any receiving state leaves the state and outputs unchanged. No timeout.
- start pulses while busy are ignored.
- busy = (state≠IDLE).

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit running XOR of all 2N data bytes is kept; it is cleared in LEN_HI.
  - CSUM accepts one byte.
    - Byte equals the XOR → FINISH, so done pulses and download_program drops.
    - Byte differs → error←1, download_program←0, → IDLE with no done pulse. Already-written words remain in the cache.
  - When N=0, the frame still carries a checksum byte, expected 8'h00.
- When undefined:
  - No CSUM state and no checksum byte; the frame ends after the last data byte.
  - error is raised only on length overflow.

Test Plan:
- Basic load: start; send A5 02 00 34 12 78 56 (plus checksum 08 if enabled). Expected:
  - (index 0, program_in 1234) then (index 1, program_in 5678).
  - download_program high from the A5 acceptance through FINISH.
  - One done pulse; error=0.
- Junk before sync: start; send 00 FF A5 01 00 CD AB. Expected: the junk bytes are ignored; download_program rises only after A5; word 0 = ABCD.
- Zero length: start; send A5 00 00 (plus 00 if enabled). Expected: no word update; done pulses; download_program high for exactly 3 cycles (LEN_LO, LEN_HI, FINISH) with byte_valid held high.
- Length overflow: MAX_WORDS=4; send A5 05 00. Expected: error=1; download_program=0; no done pulse; busy=0; a later start clears error.
- Mid-frame reset with stalls: deassert byte_valid for 5 cycles mid-word, check outputs are frozen; then pull reset_n low during DATA_HI. Expected: all outputs read 0 the next cycle.
- Bad checksum (feature enabled): send A5 01 00 11 22 with checksum 00 instead of 33. Expected: word 0 = 2211 written; error=1; no done pulse; download_program=0.
